arrow_button_receiver: RTL and testbench

- Receiving end of the four arrow-button inputs (UP, DOWN, LEFT, RIGHT) that the game top takes from the board.
- Per channel, it synchronises the raw asynchronous level and debounces it with a cycle counter.
- It emits a clean held level, plus single-cycle press and release pulses, to the step-judging logic.
- Sits between the board pins and the scoring/arrow-hit logic.

---
 rtl/arrow_button_receiver.sv | 45 ++++
 tb/tb_arrow_button_receiver.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/arrow_button_receiver.sv
// arrow_button_receiver: synchronise and debounce four arrow buttons into held levels plus press/release pulses
module arrow_button_receiver #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       LEFT,
  input  logic       RIGHT,
  output logic [3:0] held,
  output logic [3:0] press,
  output logic [3:0] rel,
  output logic       any_press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [3:0] raw, s1, s2, hit;
  logic [CNT_W-1:0] cnt [4];
  assign raw = {UP, DOWN, LEFT, RIGHT};
  always_comb begin
    hit = '0;
    for (int i = 0; i < 4; i++) hit[i] = (s2[i] != held[i]) && (cnt[i] == LAST);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
      held <= '0;
      press <= '0;
      rel <= '0;
      any_press <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      held <= held ^ hit;
      press <= hit & s2;
      rel <= hit & ~s2;
      any_press <= |(hit & s2);
      // any return to the held level restarts the count, so bounce never accumulates
      for (int i = 0; i < 4; i++) cnt[i] <= (s2[i] == held[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
endmodule

// File: tb/tb_arrow_button_receiver.sv
// tb_arrow_button_receiver: directed checks of debounce latency, pulses, glitch rejection and reset
module tb_arrow_button_receiver;
  logic clk = 0, reset = 0, UP = 0, DOWN = 0, LEFT = 0, RIGHT = 0;
  logic [3:0] held, press, rel, held1, press1, rel1;
  logic any_press, any_press1;
  int tests = 0, fails = 0, pc = 0, rc = 0, ac = 0;
  int bp, br, ba;

  always #5 clk = ~clk;

  arrow_button_receiver #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .RIGHT(RIGHT),
    .held(held), .press(press), .rel(rel), .any_press(any_press));

  arrow_button_receiver #(.DEBOUNCE_CYCLES(1), .CNT_W(1)) d1 (
    .clk(clk), .reset(reset), .UP(UP), .DOWN(DOWN), .LEFT(LEFT), .RIGHT(RIGHT),
    .held(held1), .press(press1), .rel(rel1), .any_press(any_press1));

  always @(negedge clk) if (reset) begin
    pc += $countones(press);
    rc += $countones(rel);
    ac += int'(any_press);
  end

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mark;
    bp = pc; br = rc; ba = ac;
  endtask

  initial begin
    UP = 1;
    tk(3);
    chk("reset_outputs", {held, press, rel, any_press}, 0);
    reset = 1;
    tk(5);
    chk("reset_held_e5", held, 4'b0000);
    tk(1);
    chk("reset_held_e6", held, 4'b1000);
    chk("reset_press_e6", {press, any_press}, {4'b1000, 1'b1});
    tk(1);
    chk("reset_press_e7", {held, press, any_press}, {4'b1000, 4'b0000, 1'b0});
    UP = 0;
    tk(10);
    chk("reset_up_released", held, 4'b0000);

    mark();
    LEFT = 1;
    tk(3);
    chk("d1_left_e3", held1, 4'b0010);
    tk(2);
    chk("left_rise_e5", held, 4'b0000);
    tk(1);
    chk("left_rise_e6", {held, press, rel, any_press}, {4'b0010, 4'b0010, 4'b0000, 1'b1});
    tk(1);
    chk("left_rise_e7", {press, any_press}, 0);
    tk(13);
    LEFT = 0;
    tk(3);
    chk("d1_left_fall", {held1, rel1}, {4'b0000, 4'b0010});
    tk(2);
    chk("left_fall_e5", held, 4'b0010);
    tk(1);
    chk("left_fall_e6", {held, press, rel, any_press}, {4'b0000, 4'b0000, 4'b0010, 1'b0});
    tk(1);
    chk("left_fall_e7", rel, 4'b0000);
    chk("left_pulse_counts", {8'(pc - bp), 8'(rc - br)}, {8'd1, 8'd1});

    mark();
    for (int k = 0; k < 2; k++) begin
      RIGHT = 1; tk(2);
      RIGHT = 0; tk(2);
    end
    chk("bounce_no_change", held, 4'b0000);
    RIGHT = 1;
    tk(5);
    chk("bounce_e5", held, 4'b0000);
    tk(1);
    chk("bounce_e6", {held, press}, {4'b0001, 4'b0001});
    tk(3);
    chk("bounce_one_press", 8'(pc - bp), 8'd1);
    RIGHT = 0;
    tk(10);
    mark();
    RIGHT = 1; tk(3);
    RIGHT = 0; tk(10);
    chk("glitch_held", held, 4'b0000);
    chk("glitch_no_pulse", {8'(pc - bp), 8'(rc - br)}, 0);

    mark();
    UP = 1; DOWN = 1;
    tk(6);
    chk("simul_press", {held, press, any_press}, {4'b1100, 4'b1100, 1'b1});
    tk(1);
    chk("simul_press_end", {press, any_press}, 0);
    chk("simul_any_once", 8'(ac - ba), 8'd1);
    DOWN = 0;
    tk(6);
    chk("simul_down_rel", {held, press, rel}, {4'b1000, 4'b0000, 4'b0100});
    tk(1);
    chk("simul_rel_end", {held, rel}, {4'b1000, 4'b0000});
    UP = 0;
    tk(10);

    mark();
    DOWN = 1;
    tk(3);
    reset = 0;
    #1;
    chk("midreset_no_pulse", {held, press, rel, 8'(pc - bp)}, 0);
    tk(2);
    chk("midreset_outputs", {held, press, rel, any_press}, 0);
    reset = 1;
    tk(5);
    chk("midreset_e5", held, 4'b0000);
    tk(1);
    chk("midreset_e6", {held, press}, {4'b0100, 4'b0100});
    DOWN = 0;
    tk(10);

    mark();
    UP = 1;
    tk(6);
    chk("long_press", press, 4'b1000);
    for (int k = 0; k < 100; k++) begin
      tk(1);
      chk("long_held", {held, rel}, {4'b1000, 4'b0000});
    end
    chk("long_counts", {8'(pc - bp), 8'(rc - br)}, {8'd1, 8'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
